num_field_extender: RTL and testbench
=====================================

Name: num_field_extender

Overview:
- Registered, buffered width-adaptation stage that feeds the fixed-width number consumers.
- Accepts one narrow field per transfer, 1 to IN_W bits wide, together with a runtime width code and a signedness flag.
- Sign-extends or zero-extends each field to OUT_W bits.
- Queues results in a small FIFO behind a valid/ready handshake, and keeps a running transfer count for debug.

Parameters:
- IN_W, 5: maximum input field width in bits. Legal range 1..7.
- OUT_W, 8: output width in bits. Must satisfy OUT_W >= IN_W+1. Elaboration error otherwise.
- DEPTH, 2: output FIFO depth in entries. Legal range 2..8.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream presents a field.
- in_ready  output  1  stage can accept a field this cycle.
- in_data  input  IN_W  field bits, LSB-aligned.
- in_width  input  3  number of meaningful bits, 1..IN_W.
- in_signed  input  1  1 = two's-complement field, 0 = unsigned field.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  downstream accepts the head this cycle.
- out_data  output  OUT_W  extended value at the FIFO head (signed).
- out_err  output  1  head entry was produced from an illegal in_width.
- out_count  output  16  number of completed output transfers, wraps modulo 2^16.

Behaviour:
- Reset (rst_n low, async assert, sync deassert handled by the top level):
  - FIFO emptied; out_valid=0, out_data=0, out_err=0, out_count=0, in_ready=0 while rst_n low.
  - Reset mid-transfer discards all queued entries. No partial state survives.
- Handshakes:
  - Input transfer when in_valid & in_ready on a rising edge.
  - Output transfer when out_valid & out_ready.
  - in_ready = (occupancy < DEPTH). It is registered-state-derived only, with no combinational path from out_ready.
  - out_valid = (occupancy > 0).
- Extension (combinational on the input side, written into the FIFO at acceptance). Let w = in_width.
  - Legal w (1 <= w <= IN_W): bits in_data[IN_W-1:w] are ignored.
  - in_signed=1: out bits [OUT_W-1:w] = in_data[w-1].
  - in_signed=0: out bits [OUT_W-1:w] = 0.
  - Low w bits copied unchanged.
  - Illegal w (0 or > IN_W): entry stored with data=0, err=1. It still occupies a FIFO slot and must be consumed normally.
- Latency:
  - A field accepted at edge N appears at the head no earlier than after edge N (visible in cycle N+1) when the FIFO was empty.
  - No zero-cycle bypass.
- FIFO:
  - Circular buffer, read and write pointers wrap at DEPTH, plus an occupancy counter.
  - Strict order preserved.
  - Simultaneous push and pop when 0 < occupancy < DEPTH: occupancy unchanged, both pointers advance.
  - Simultaneous push and pop when empty: impossible, out_valid=0.
  - Push when full: impossible, in_ready=0.
  - out_data/out_err hold stable while out_valid=1 and out_ready=0.
  - When empty, out_data/out_err show the last popped values, or 0 after reset; consumers must qualify with out_valid.
- out_count:
  - Increments by 1 on each output transfer.
  - 16'hFFFF + 1 -> 16'h0000.
  - Not affected by input transfers.
- in_data, in_width, in_signed are sampled only on an accepted transfer. Changes while in_valid=0 or in_ready=0 have no effect.

Test Plan:
- Reset, then in_data=5'b00001, in_width=1, in_signed=1, out_ready=1 -> next cycle out_valid=1, out_data=8'hFF, out_err=0, out_count becomes 1 after the transfer.
- Same field with in_signed=0 -> out_data=8'h01. Then in_data=5'b10110, w=3, signed -> 8'hFE (bit4 ignored). Same with w=5, signed -> 8'hF6; unsigned -> 8'h16.
- out_ready=0, push three fields back-to-back with DEPTH=2 -> in_ready drops after the second acceptance, the third is held upstream. Raise out_ready -> the three values emerge in order with no loss or duplication.
- Occupancy 1, in_valid=1 and out_ready=1 held for 20 cycles with incrementing fields -> one transfer per cycle on both sides, occupancy constant at 1, order preserved.
- in_width=0 and in_width=6 -> entries with out_data=8'h00, out_err=1, FIFO order kept relative to neighbouring legal entries.
- Two entries queued, assert rst_n low mid-cycle -> out_valid and out_count clear immediately (asynchronously). After release, no stale entry ever appears. Separately, preload traffic so out_count wraps from 16'hFFFF to 16'h0000.

Source files
------------

// File: rtl/num_field_extender.sv
// num_field_extender
// Widens a 1..IN_W bit field to OUT_W bits (sign or zero fill), then queues
// the result in a small circular FIFO behind a valid/ready handshake.
// A running count of completed output transfers is kept for debug.
// A field with an out-of-range width code still takes a FIFO slot: it is
// stored as data 0 with the error flag set, so ordering against its
// neighbours is preserved.
module num_field_extender #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [2:0]       in_width,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [15:0]      out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Reject parameter sets the datapath cannot support.
    generate
        if (IN_W < 1 || IN_W > 7) begin : g_bad_in_w
            $error("num_field_extender: IN_W must be in 1..7");
        end
        if (OUT_W < IN_W + 1) begin : g_bad_out_w
            $error("num_field_extender: OUT_W must be at least IN_W+1");
        end
        if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
            $error("num_field_extender: DEPTH must be in 2..8");
        end
    endgenerate

    logic [OUT_W-1:0] r_mem_data [DEPTH];
    logic             r_mem_err  [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [OUT_W-1:0] r_last_data;
    logic             r_last_err;
    logic [15:0]      r_xfer_count;

    logic             w_legal;
    logic             w_sign_bit;
    logic             w_fill;
    logic [OUT_W-1:0] w_ext_data;
    logic             w_push;
    logic             w_pop;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    // Extension of the incoming field; bits at and above the width are replaced.
    always_comb begin
        w_legal    = (in_width != 3'd0) && (int'(in_width) <= IN_W);
        w_sign_bit = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (i == int'(in_width) - 1) begin
                w_sign_bit = in_data[i];
            end
        end
        w_fill     = in_signed & w_sign_bit;
        w_ext_data = '0;
        if (w_legal) begin
            for (int i = 0; i < IN_W; i++) begin
                w_ext_data[i] = (i < int'(in_width)) ? in_data[i] : w_fill;
            end
            for (int i = IN_W; i < OUT_W; i++) begin
                w_ext_data[i] = w_fill;
            end
        end
    end

    // in_ready depends only on stored occupancy (and reset), never on out_ready.
    assign in_ready  = rst_n & (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // When empty the outputs fall back to the last popped entry.
    assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : r_last_data;
    assign out_err   = out_valid ? r_mem_err[r_rd_ptr]  : r_last_err;
    assign out_count = r_xfer_count;

    // FIFO storage, pointers, occupancy and last-popped capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_err[i]  <= 1'b0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_data <= '0;
            r_last_err  <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_ext_data;
                r_mem_err[r_wr_ptr]  <= ~w_legal;
                r_wr_ptr             <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_last_data <= r_mem_data[r_rd_ptr];
                r_last_err  <= r_mem_err[r_rd_ptr];
                r_rd_ptr    <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Completed output transfers, wrapping modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_pop) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_num_field_extender.sv
// Testbench for num_field_extender: directed cases, randomized traffic,
// mid-traffic reset and out_count wrap, checked through a scoreboard queue.
module tb_num_field_extender;

    localparam int IN_W  = 5;
    localparam int OUT_W = 8;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [2:0]       in_width;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;
    logic [15:0]      out_count;

    num_field_extender #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_width  (in_width),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [8:0]  q_exp [$];
    logic [8:0]  m_last = 9'h000;
    logic [15:0] m_cnt = 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: keep the low w bits as a number, reinterpret as two's complement if signed.
    function automatic logic [8:0] model(input logic [4:0] d, input logic [2:0] w, input logic s);
        int v;
        int wi;
        wi = int'(w);
        if (wi < 1 || wi > IN_W) return {1'b1, 8'h00};
        v = int'(d) % (1 << wi);
        if (s && v >= (1 << (wi - 1))) v = v - (1 << wi);
        return {1'b0, 8'(v)};
    endfunction

    // Monitor: checks handshake flags, head contents and count, pops on output transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_count", 32'(out_count), 32'd0);
        end else begin
            chk("in_ready", 32'(in_ready), 32'(q_exp.size() < DEPTH));
            chk("out_valid", 32'(out_valid), 32'(q_exp.size() > 0));
            chk("out_count", 32'(out_count), 32'(m_cnt));
            if (q_exp.size() > 0) begin
                chk("head", 32'({out_err, out_data}), 32'(q_exp[0]));
                if (out_valid && out_ready) begin
                    m_last = q_exp.pop_front();
                    m_cnt  = m_cnt + 16'd1;
                end
            end else begin
                chk("idle_hold", 32'({out_err, out_data}), 32'(m_last));
            end
        end
    end

    // Offer one field; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic send(input logic [4:0] d, input logic [2:0] w, input logic s, output int cyc);
        logic acc;
        cyc = 0;
        acc = 1'b0;
        in_data   = d;
        in_width  = w;
        in_signed = s;
        in_valid  = 1'b1;
        while (!acc && cyc < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        if (acc) q_exp.push_back(model(d, w, s));
        else chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (q_exp.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 32'(q_exp.size()), 32'd0);
    endtask

    int  cyc;
    int  cyc3;
    bit  rnd_done;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_width  = 3'd0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed extension cases with a free-running consumer.
        out_ready = 1'b1;
        send(5'b00001, 3'd1, 1'b1, cyc);
        send(5'b00001, 3'd1, 1'b0, cyc);
        send(5'b10110, 3'd3, 1'b1, cyc);
        send(5'b10110, 3'd5, 1'b1, cyc);
        send(5'b10110, 3'd5, 1'b0, cyc);
        send(5'b01111, 3'd4, 1'b1, cyc);
        drain();

        // Backpressure: three fields against a stalled consumer.
        out_ready = 1'b0;
        fork
            begin
                send(5'h03, 3'd5, 1'b0, cyc);
                send(5'h1C, 3'd5, 1'b1, cyc);
                send(5'h0A, 3'd4, 1'b1, cyc3);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        chk("third_held", 32'(cyc3 > 1), 32'd1);
        drain();

        // Streaming at occupancy 1: one transfer per cycle on both sides.
        out_ready = 1'b0;
        send(5'h00, 3'd5, 1'b0, cyc);
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            send(5'(i), 3'd5, 1'b1, cyc);
            chk("stream_1cyc", 32'(cyc), 32'd1);
        end
        drain();

        // Illegal widths between legal neighbours.
        out_ready = 1'b0;
        send(5'h05, 3'd3, 1'b0, cyc);
        fork
            begin
                send(5'h1F, 3'd0, 1'b1, cyc);
                send(5'h1F, 3'd6, 1'b1, cyc);
                send(5'h12, 3'd7, 1'b0, cyc);
                send(5'h11, 3'd5, 1'b1, cyc);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Randomized traffic with a randomly stalling consumer.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), cyc);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Reset with two entries queued: everything clears at once, nothing stale returns.
        out_ready = 1'b0;
        send(5'h07, 3'd3, 1'b1, cyc);
        send(5'h09, 3'd4, 1'b0, cyc);
        chk("pre_rst_count_nz", 32'(m_cnt != 16'd0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_count", 32'(out_count), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        q_exp.delete();
        m_cnt  = 16'h0000;
        m_last = 9'h000;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Sustained streaming long enough for out_count to wrap.
        out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            send(5'($urandom_range(0, 31)), 3'($urandom_range(1, 5)),
                 1'($urandom_range(0, 1)), cyc);
        end
        drain();
        @(negedge clk);
        chk("count_wrapped", 32'(out_count), 32'd4);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
